// File: rtl/ted_pio_pkg.sv
// Purpose: shared bit positions of the PIO command and status words.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ted_pio_pkg;

    // Command word written by software through the output PIO
    localparam int CMD_TOGGLE_BIT = 31;
    localparam int CMD_LAST_BIT   = 30;
    localparam int CMD_CLR_BIT    = 29;

    // Status word read back by software through the input PIO
    localparam int STS_ACK_BIT    = 31;
    localparam int STS_OVF_BIT    = 30;
    localparam int STS_FULL_BIT   = 29;
    localparam int STS_EMPTY_BIT  = 28;

    // Idle status: FIFO empty, every flag clear
    localparam logic [31:0] STS_RESET = 32'(1) << STS_EMPTY_BIT;

endpackage

// File: rtl/ted_sync_fifo.sv
// Purpose: register-array first-word-fall-through FIFO with full/empty/level.
// Latency: a pushed word is at the head the cycle after the push edge.
// Backpressure: push when full is taken only with a same-cycle pop; pop when empty is ignored.
module ted_sync_fifo
    import ted_pio_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [2**AW];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Advance the pointers on accepted pushes and pops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: stale entries are never visible past the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ted_pio_cmd_bridge.sv
// Purpose: turns toggle-handshake PIO command words into a valid/ready payload stream.
// Latency: event at edge N -> m_valid and updated status_word in the cycle after edge N.
// Backpressure: m_ready low holds the head; a word arriving when full with no pop is dropped and flags overflow.
module ted_pio_cmd_bridge
    import ted_pio_pkg::*;
#(
    parameter int PAYLOAD_W = 16,
    parameter int FIFO_AW   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          cmd_word,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PAYLOAD_W-1:0] m_data,
    output logic                 m_last,
    output logic [31:0]          status_word
);

    localparam int DEPTH = 2**FIFO_AW;

    logic                 prev_toggle;
    logic                 ack_toggle;
    logic                 overflow;
    logic                 cmd_event;
    logic                 is_clr;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 full;
    logic                 empty;
    logic [FIFO_AW:0]     level;
    logic [FIFO_AW:0]     level_next;
    logic [PAYLOAD_W:0]   head;
    logic                 ack_next;
    logic                 ovf_next;
    logic [31:0]          status_next;

    // A command is a change of the toggle bit relative to the last one seen
    assign cmd_event = (cmd_word[CMD_TOGGLE_BIT] != prev_toggle);
    assign is_clr    = cmd_word[CMD_CLR_BIT];
    assign pop       = m_valid && m_ready;
    assign push      = cmd_event && !is_clr && (!full || pop);
    assign drop      = cmd_event && !is_clr && full && !pop;

    assign m_valid         = !empty;
    assign {m_last, m_data} = m_valid ? head : '0;

    ted_sync_fifo #(
        .WIDTH (PAYLOAD_W + 1),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({cmd_word[CMD_LAST_BIT], cmd_word[PAYLOAD_W-1:0]}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // Bits between the flags and the payload carry nothing
    if (PAYLOAD_W < 29) begin : g_unused
        logic unused_cmd_bits;
        assign unused_cmd_bits = ^cmd_word[28:PAYLOAD_W];
    end

    // Toggle detector, ack echo and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_toggle <= 1'b0;
            ack_toggle  <= 1'b0;
            overflow    <= 1'b0;
        end else if (cmd_event) begin
            prev_toggle <= cmd_word[CMD_TOGGLE_BIT];
            ack_toggle  <= ~ack_toggle;
            if (is_clr)    overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;
        end
    end

    // Next-state view of the flags and occupancy, so the status register lands with the state
    always_comb begin
        level_next  = level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        ack_next    = ack_toggle ^ cmd_event;
        ovf_next    = overflow;
        if (cmd_event && is_clr) ovf_next = 1'b0;
        else if (drop)           ovf_next = 1'b1;
        status_next                = '0;
        status_next[STS_ACK_BIT]   = ack_next;
        status_next[STS_OVF_BIT]   = ovf_next;
        status_next[STS_FULL_BIT]  = (level_next == (FIFO_AW+1)'(DEPTH));
        status_next[STS_EMPTY_BIT] = (level_next == '0);
        status_next[FIFO_AW:0]     = level_next;
    end

    // Registered status word for the input PIO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) status_word <= STS_RESET;
        else       status_word <= status_next;
    end

endmodule

// File: tb/tb_ted_pio_cmd_bridge.sv
// Purpose: self-checking bench for ted_pio_cmd_bridge against a queue-based software-view model.
// Latency: checks each cycle on the falling edge, after the rising-edge update.
// Backpressure: m_ready is driven directed and randomly to exercise full, drop and same-cycle push/pop.
module tb_ted_pio_cmd_bridge;

    localparam int PW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   cmd_word;
    logic          m_valid;
    logic          m_ready;
    logic [PW-1:0] m_data;
    logic          m_last;
    logic [31:0]   status_word;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queued {last,payload} words plus the software-visible flags
    logic [PW:0] mq[$];
    bit sw_tog;
    bit m_prev;
    bit m_ack;
    bit m_ovf;

    ted_pio_cmd_bridge #(
        .PAYLOAD_W (PW),
        .FIFO_AW   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_word    (cmd_word),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .status_word (status_word)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s     = '0;
        s[31] = m_ack;
        s[30] = m_ovf;
        s[29] = (mq.size() == DEPTH);
        s[28] = (mq.size() == 0);
        s[3:0] = 4'(mq.size());
        return s;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_prev = 1'b0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    // Check outputs against the model, then let one rising edge happen and update the model
    task automatic cycle();
        bit          popped;
        bit          evt;
        int          sz0;
        logic [PW:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("m_valid", 32'(m_valid), 32'(mq.size() > 0));
        chk("m_data",  32'(m_data),  32'(head[PW-1:0]));
        chk("m_last",  32'(m_last),  32'(head[PW]));
        chk("status",  status_word,  exp_status());
        sz0    = mq.size();
        popped = (sz0 > 0) && m_ready;
        evt    = (cmd_word[31] != m_prev);
        @(posedge clk);
        @(negedge clk);
        if (popped) void'(mq.pop_front());
        if (evt) begin
            m_prev = cmd_word[31];
            m_ack  = ~m_ack;
            if (cmd_word[29])                 m_ovf = 1'b0;
            else if (sz0 < DEPTH || popped)   mq.push_back({cmd_word[30], cmd_word[PW-1:0]});
            else                              m_ovf = 1'b1;
        end
    endtask

    // Software write: flip the toggle, fill the ignored bits with junk
    task automatic send(input bit last, input bit clr, input logic [PW-1:0] pl);
        sw_tog   = ~sw_tog;
        cmd_word = {sw_tog, last, clr, 13'($urandom), pl};
        cycle();
    endtask

    initial begin
        bit seen_aa;
        bit aa_last;
        reset    = 1'b1;
        cmd_word = '0;
        m_ready  = 1'b0;
        sw_tog   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: idle after reset
        repeat (10) cycle();
        chk("s1_status", status_word, 32'h1000_0000);
        chk("s1_valid", 32'(m_valid), 32'd0);

        // 2: single word, static afterwards
        m_ready  = 1'b1;
        sw_tog   = 1'b1;
        cmd_word = 32'h8000_1234;
        cycle();
        chk("s2_data", 32'(m_data), 32'h1234);
        chk("s2_ack", 32'(status_word[31]), 32'd1);
        repeat (5) cycle();
        chk("s2_norepeat", 32'(m_valid), 32'd0);

        // 3: fill, overflow with a ninth word
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0, PW'(i));
        send(1'b0, 1'b0, 16'h0009);
        chk("s3_full", 32'(status_word[29]), 32'd1);
        chk("s3_level", 32'(status_word[3:0]), 32'd8);
        chk("s3_ovf", 32'(status_word[30]), 32'd1);
        chk("s3_ack", 32'(status_word[31]), 32'd0);

        // 4: clear overflow while full, then drain
        send(1'b0, 1'b1, 16'hBEEF);
        chk("s4_ovf", 32'(status_word[30]), 32'd0);
        chk("s4_level", 32'(status_word[3:0]), 32'd8);
        m_ready = 1'b1;
        repeat (12) cycle();
        chk("s4_empty", status_word, {m_ack, 31'h1000_0000});

        // 5: push and pop in the same cycle while full, then a last-flagged word
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0, PW'(16'h0100 + i));
        m_ready = 1'b1;
        send(1'b0, 1'b0, 16'h0200);
        chk("s5_level", 32'(status_word[3:0]), 32'd8);
        chk("s5_ovf", 32'(status_word[30]), 32'd0);
        send(1'b1, 1'b0, 16'h00AA);
        seen_aa = 1'b0;
        aa_last = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (m_valid && m_data == 16'h00AA) begin
                seen_aa = 1'b1;
                aa_last = m_last;
            end
            cycle();
        end
        chk("s5_seen_aa", 32'(seen_aa), 32'd1);
        chk("s5_last_aa", 32'(aa_last), 32'd1);

        // 6: reset mid-stream with 5 queued words
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0, PW'(16'h0300 + i));
        chk("s6_level_pre", 32'(status_word[3:0]), 32'd5);
        #2;
        reset    = 1'b1;
        cmd_word = '0;
        sw_tog   = 1'b0;
        #1;
        chk("s6_valid", 32'(m_valid), 32'd0);
        chk("s6_status", status_word, 32'h1000_0000);
        model_reset();
        @(negedge clk);
        reset   = 1'b0;
        m_ready = 1'b1;
        send(1'b0, 1'b0, 16'h5A5A);
        chk("s6_data", 32'(m_data), 32'h5A5A);
        repeat (3) cycle();

        // Random traffic: sparse ready first to hit full/drop, then mostly ready
        for (int i = 0; i < 600; i++) begin
            m_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                send(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), PW'($urandom));
            else
                cycle();
        end
        m_ready = 1'b1;
        repeat (12) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
